// File: rtl/frame_capture_scheduler.sv
// Frame-aligned capture sequencer: turns mouse clicks into a frame buffer write
// enable that opens on frame_start and closes on frame_done or watchdog abort.
module frame_capture_scheduler #(
    parameter int                   CNT_W     = 16,
    parameter int                   TIMEOUT_W = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 24'd1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mouse_left,
    input  logic             mouse_right,
    input  logic             frame_start,
    input  logic             frame_done,
    output logic             capture_en,
    output logic             mode_single,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] frame_count
);

    typedef enum logic [2:0] {
        C_WAIT,
        C_CAP,
        S_IDLE,
        S_ARMED,
        S_CAP
    } state_t;

    localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT - 1'b1;

    state_t               state, next_state;
    logic                 pending_toggle, pending_next;
    logic [TIMEOUT_W-1:0] watchdog, watchdog_next;
    logic                 left_q, right_q;
    logic                 l_edge, r_edge;
    logic                 in_cap, next_in_cap, expired, toggle;
    logic                 done_ok, abort;

    // A right click in the same cycle as a left click swallows the left click.
    assign r_edge = mouse_right & ~right_q;
    assign l_edge = mouse_left & ~left_q & ~r_edge;

    assign in_cap      = (state == C_CAP) || (state == S_CAP);
    assign next_in_cap = (next_state == C_CAP) || (next_state == S_CAP);
    assign expired     = in_cap && (watchdog == WD_LAST) && !frame_done;
    assign toggle      = pending_toggle | r_edge;

    always_comb begin
        next_state   = state;
        pending_next = pending_toggle;
        done_ok      = 1'b0;
        abort        = 1'b0;
        case (state)
            C_WAIT: begin
                if (r_edge)           next_state = S_IDLE;
                else if (frame_start) next_state = C_CAP;
            end
            C_CAP: begin
                if (frame_done || expired) begin
                    done_ok      = frame_done;
                    abort        = !frame_done;
                    pending_next = 1'b0;
                    if (toggle)                         next_state = S_IDLE;
                    else if (frame_done && frame_start) next_state = C_CAP;
                    else                                next_state = C_WAIT;
                end else begin
                    pending_next = toggle;
                end
            end
            S_IDLE: begin
                if (r_edge)      next_state = C_WAIT;
                else if (l_edge) next_state = S_ARMED;
            end
            S_ARMED: begin
                if (r_edge)           next_state = C_WAIT;
                else if (frame_start) next_state = S_CAP;
            end
            S_CAP: begin
                // Single mode never chains into a coincident frame_start.
                if (frame_done || expired) begin
                    done_ok      = frame_done;
                    abort        = !frame_done;
                    pending_next = 1'b0;
                    next_state   = toggle ? C_WAIT : S_IDLE;
                end else begin
                    pending_next = toggle;
                end
            end
            default: begin
                next_state   = C_WAIT;
                pending_next = 1'b0;
            end
        endcase
    end

    always_comb begin
        watchdog_next = '0;
        if (next_in_cap && in_cap && !done_ok)
            watchdog_next = watchdog + TIMEOUT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= C_WAIT;
            pending_toggle <= 1'b0;
            watchdog       <= '0;
            left_q         <= 1'b0;
            right_q        <= 1'b0;
            capture_en     <= 1'b0;
            mode_single    <= 1'b0;
            busy           <= 1'b0;
            timeout_err    <= 1'b0;
            frame_count    <= '0;
        end else begin
            state          <= next_state;
            pending_toggle <= pending_next;
            watchdog       <= watchdog_next;
            left_q         <= mouse_left;
            right_q        <= mouse_right;
            capture_en     <= next_in_cap;
            mode_single    <= (next_state == S_IDLE) || (next_state == S_ARMED) ||
                              (next_state == S_CAP);
            busy           <= (next_state == S_ARMED) || next_in_cap;
            timeout_err    <= abort;
            if (done_ok)
                frame_count <= frame_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_frame_capture_scheduler.sv
// Bench for frame_capture_scheduler: a default-timeout instance for the protocol
// scenarios and a TIMEOUT=50 instance for watchdog behaviour, sharing stimulus.
module tb_frame_capture_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mouse_left = 1'b0;
    logic        mouse_right = 1'b0;
    logic        frame_start = 1'b0;
    logic        frame_done = 1'b0;

    logic        capture_en, mode_single, busy, timeout_err;
    logic [15:0] frame_count;
    logic        to_capture_en, to_mode_single, to_busy, to_timeout_err;
    logic [15:0] to_frame_count;

    // Observation word: {capture_en, busy, mode_single, timeout_err, frame_count}
    logic [19:0] obs_main, obs_to, e;
    logic [19:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    assign obs_main = {capture_en, busy, mode_single, timeout_err, frame_count};
    assign obs_to   = {to_capture_en, to_busy, to_mode_single, to_timeout_err, to_frame_count};

    always #5 clk = ~clk;

    frame_capture_scheduler dut (
        .clk(clk), .rst_n(rst_n), .mouse_left(mouse_left), .mouse_right(mouse_right),
        .frame_start(frame_start), .frame_done(frame_done), .capture_en(capture_en),
        .mode_single(mode_single), .busy(busy), .timeout_err(timeout_err),
        .frame_count(frame_count)
    );

    frame_capture_scheduler #(.CNT_W(16), .TIMEOUT_W(24), .TIMEOUT(24'd50)) dut_to (
        .clk(clk), .rst_n(rst_n), .mouse_left(mouse_left), .mouse_right(mouse_right),
        .frame_start(frame_start), .frame_done(frame_done), .capture_en(to_capture_en),
        .mode_single(to_mode_single), .busy(to_busy), .timeout_err(to_timeout_err),
        .frame_count(to_frame_count)
    );

    task automatic tick(input logic s, input logic d);
        @(negedge clk);
        frame_start = s;
        frame_done  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mouse_left = 1'b0; mouse_right = 1'b0; frame_start = 1'b0; frame_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [19:0] ev(logic c, logic b, logic m, logic t, logic [15:0] n);
        return {c, b, m, t, n};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        exp_q.push_back(20'h0);
        exp_q.push_back(20'h0);
        e = exp_q.pop_front(); n_cmp++;
        if (obs_main !== e) begin
            n_err++; $display("FAIL reset_main: actual=%h required=%h", obs_main, e);
        end
        e = exp_q.pop_front(); n_cmp++;
        if (obs_to !== e) begin
            n_err++; $display("FAIL reset_to: actual=%h required=%h", obs_to, e);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_continuous();
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < 105; c++) begin
                exp_q.push_back(ev(c < 99, c < 99, 1'b0, 1'b0, 16'(f + ((c >= 99) ? 1 : 0))));
                tick(c == 0, c == 99);
                e = exp_q.pop_front(); n_cmp++;
                if (obs_main !== e) begin
                    n_err++;
                    $display("FAIL continuous f%0d c%0d: actual=%h required=%h", f, c, obs_main, e);
                end
            end
        end
    endtask

    task automatic test_mode_toggle();
        for (int c = 0; c < 50; c++) begin
            mouse_right = (c == 11);
            if (c < 23)       exp_q.push_back(ev(1, 1, 0, 0, 16'd3));
            else              exp_q.push_back(ev(0, 0, 1, 0, 16'd4));
            tick(c == 0 || c == 25, c == 23 || c == 45);
            e = exp_q.pop_front(); n_cmp++;
            if (obs_main !== e) begin
                n_err++;
                $display("FAIL mode_toggle c%0d: actual=%h required=%h", c, obs_main, e);
            end
        end
        mouse_right = 1'b0;
    endtask

    task automatic test_single_shot();
        for (int c = 0; c < 60; c++) begin
            mouse_left = (c == 0) || (c == 10);
            if (c < 4)        exp_q.push_back(ev(0, 1, 1, 0, 16'd4));
            else if (c < 25)  exp_q.push_back(ev(1, 1, 1, 0, 16'd4));
            else              exp_q.push_back(ev(0, 0, 1, 0, 16'd5));
            tick(c == 4 || c == 30, c == 25 || c == 50);
            e = exp_q.pop_front(); n_cmp++;
            if (obs_main !== e) begin
                n_err++;
                $display("FAIL single_shot c%0d: actual=%h required=%h", c, obs_main, e);
            end
        end
        mouse_left = 1'b0;
    endtask

    task automatic test_simultaneous_clicks();
        for (int c = 0; c < 6; c++) begin
            mouse_left  = (c == 0);
            mouse_right = (c == 0);
            if (c < 2)       exp_q.push_back(ev(0, 0, 0, 0, 16'd5));
            else if (c < 4)  exp_q.push_back(ev(1, 1, 0, 0, 16'd5));
            else             exp_q.push_back(ev(0, 0, 0, 0, 16'd6));
            tick(c == 2, c == 4);
            e = exp_q.pop_front(); n_cmp++;
            if (obs_main !== e) begin
                n_err++;
                $display("FAIL simultaneous c%0d: actual=%h required=%h", c, obs_main, e);
            end
        end
        mouse_left = 1'b0; mouse_right = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 25; c++) begin
            if (c < 11)       exp_q.push_back(ev(1, 1, 0, 0, 16'd6));
            else if (c < 22)  exp_q.push_back(ev(1, 1, 0, 0, 16'd7));
            else              exp_q.push_back(ev(0, 0, 0, 0, 16'd8));
            tick(c == 0 || c == 11, c == 11 || c == 22);
            e = exp_q.pop_front(); n_cmp++;
            if (obs_main !== e) begin
                n_err++;
                $display("FAIL back_to_back c%0d: actual=%h required=%h", c, obs_main, e);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(1'b1, 1'b0);
        exp_q.push_back(ev(1, 1, 0, 0, 16'd0));
        e = exp_q.pop_front(); n_cmp++;
        if (obs_main !== e) begin
            n_err++; $display("FAIL async_pre: actual=%h required=%h", obs_main, e);
        end
        frame_start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(20'h0);
        e = exp_q.pop_front(); n_cmp++;
        if (obs_main !== e) begin
            n_err++; $display("FAIL async_reset: actual=%h required=%h", obs_main, e);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_timeout();
        do_reset();
        for (int c = 0; c <= 52; c++) begin
            if (c < 50)       exp_q.push_back(ev(1, 1, 0, 0, 16'd0));
            else if (c == 50) exp_q.push_back(ev(0, 0, 0, 1, 16'd0));
            else              exp_q.push_back(ev(0, 0, 0, 0, 16'd0));
            tick(c == 0, 1'b0);
            e = exp_q.pop_front(); n_cmp++;
            if (obs_to !== e) begin
                n_err++;
                $display("FAIL timeout_abort c%0d: actual=%h required=%h", c, obs_to, e);
            end
        end
        for (int c = 0; c <= 52; c++) begin
            if (c < 50)       exp_q.push_back(ev(1, 1, 0, 0, 16'd0));
            else              exp_q.push_back(ev(0, 0, 0, 0, 16'd1));
            tick(c == 0, c == 50);
            e = exp_q.pop_front(); n_cmp++;
            if (obs_to !== e) begin
                n_err++;
                $display("FAIL timeout_done_wins c%0d: actual=%h required=%h", c, obs_to, e);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        tick(1'b1, 1'b0);
        for (int i = 0; i < 65535; i++) begin
            @(negedge clk);
            frame_start = 1'b1;
            frame_done  = 1'b1;
        end
        @(posedge clk);
        #1;
        exp_q.push_back(ev(1, 1, 0, 0, 16'hFFFF));
        e = exp_q.pop_front(); n_cmp++;
        if (obs_main !== e) begin
            n_err++; $display("FAIL wrap_full: actual=%h required=%h", obs_main, e);
        end
        exp_q.push_back(ev(0, 0, 0, 0, 16'h0000));
        tick(1'b0, 1'b1);
        e = exp_q.pop_front(); n_cmp++;
        if (obs_main !== e) begin
            n_err++; $display("FAIL wrap_zero: actual=%h required=%h", obs_main, e);
        end
        tick(1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_mode_toggle();
        test_single_shot();
        test_simultaneous_clicks();
        test_back_to_back();
        test_async_reset();
        test_timeout();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/frame_capture_scheduler.md
Name: frame_capture_scheduler

Overview:
- Sequences camera-frame capture into the frame buffer for the face-detection pipeline, driven by the mouse buttons.
- Replaces the free-running "continue" level with a frame-aligned write enable:
  - capture always starts on a frame-start pulse;
  - capture always ends on the frame buffer's frame-done pulse.
- Supports continuous and single-shot modes, defers mode changes to frame boundaries, counts captured frames, and aborts stalled captures via a timeout.

Parameters:
- CNT_W, 16, width of the captured-frame counter (wraps).
- TIMEOUT_W, 24, width of the per-frame watchdog counter.
- TIMEOUT, 24'd1_000_000, max clk cycles a capture may stay open before abort.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mouse_left  input  1  left button level, clk-synchronous; rising edge = capture request.
- mouse_right  input  1  right button level, clk-synchronous; rising edge = mode toggle.
- frame_start  input  1  one-cycle pulse at first pixel of a camera frame.
- frame_done  input  1  one-cycle pulse from frame buffer when last pixel is written.
- capture_en  output  1  frame buffer write enable (registered).
- mode_single  output  1  1 = single-shot mode, 0 = continuous (registered).
- busy  output  1  1 while armed or capturing (registered).
- timeout_err  output  1  one-cycle pulse on watchdog abort (registered).
- frame_count  output  CNT_W  frames completed successfully (registered).

Behaviour:
- Reset (rst_n low, async):
  - state = C_WAIT; capture_en = 0, mode_single = 0, busy = 0, timeout_err = 0, frame_count = 0;
  - watchdog = 0; pending_toggle = 0; button history regs = 0 (a button held through reset yields one edge after release of reset).
- Edge detect: l_edge = mouse_left & ~left_q; r_edge = mouse_right & ~right_q.
  - l_edge and r_edge in the same cycle: r_edge wins, l_edge is discarded.
- States:
  - C_WAIT:
    - frame_start -> C_CAP.
    - r_edge -> S_IDLE (immediate, no capture open).
  - C_CAP:
    - r_edge sets pending_toggle.
    - frame_done with pending_toggle=1 -> S_IDLE (clear pending_toggle).
    - frame_done with pending_toggle=0 and frame_start in the same cycle -> stay C_CAP (back-to-back frames).
    - frame_done with pending_toggle=0, no frame_start -> C_WAIT.
  - S_IDLE:
    - l_edge -> S_ARMED.
    - r_edge -> C_WAIT.
  - S_ARMED:
    - frame_start -> S_CAP.
    - r_edge -> C_WAIT (capture cancelled).
    - further l_edge ignored.
  - S_CAP:
    - l_edge ignored; r_edge sets pending_toggle.
    - frame_done -> S_IDLE, or C_WAIT if pending_toggle (then clear it).
    - a frame_start coincident with frame_done is NOT taken in single mode.
- Outputs, all registered from next-state (visible the cycle after the triggering input):
  - capture_en = 1 in C_CAP and S_CAP.
  - busy = 1 in S_ARMED, C_CAP, S_CAP.
  - mode_single = 1 in S_*.
  - Latency: frame_start at edge k -> capture_en high from edge k; frame_done at edge k -> capture_en low from edge k (unless back-to-back in continuous mode).
- frame_count:
  - +1 on every frame_done accepted in C_CAP/S_CAP; wraps from all-ones to 0.
  - frame_done outside a CAP state is ignored and not counted.
- Watchdog:
  - Clears on entry to any CAP state and on each accepted frame_done; increments each cycle in CAP.
  - At watchdog == TIMEOUT-1 without frame_done: pulse timeout_err, drop capture_en, no count increment.
  - Next state after abort: C_WAIT (continuous) or S_IDLE (single); pending_toggle is applied as at frame_done.
  - frame_done in the same cycle as expiry: frame_done wins (counted, no error).
- frame_start while already in CAP without frame_done: ignored.

Test Plan:
- Reset, then 3 frames of frame_start..frame_done (100 cycles each) -> capture_en high exactly during each frame; frame_count=3; mode_single=0.
- Continuous mode, right click mid-frame -> capture_en stays high until frame_done; then mode_single=1, capture_en=0; next frame_start leaves capture_en=0.
- Single mode, left click then 2 frames -> exactly the first frame captured (frame_count +1); busy 1 from click to frame_done; S_IDLE afterwards.
- Left and right rising edges in the same cycle while in S_IDLE -> C_WAIT; no arming; mode_single=0.
- TIMEOUT=50, frame_start with no frame_done -> capture_en low and timeout_err pulse exactly 50 cycles after entry; frame_count unchanged. Repeat with frame_done on cycle 50 -> counted, no error.
- Continuous, frame_done and frame_start coincident -> capture_en stays continuously high; frame_count +1. frame_count at 16'hFFFF + one frame -> 0. Async rst_n low mid-capture -> capture_en=0 immediately.
